fracnet_sdiv_q16: RTL

Sequential signed-by-unsigned divider, the inverse of the accelerator's unsigned-15 × signed-16 → signed-31 product unit. Takes a signed 31-bit accumulated product and an unsigned 15-bit scale and recovers a signed 16-bit quotient with truncation toward zero, a remainder, and overflow and divide-by-zero flags. It sits on the requantization path after accumulation and uses the ap_ctrl_hs block-level handshake.

---
 rtl/fracnet_sdiv_q16_pkg.sv | 49 ++++
 rtl/fracnet_sdiv_q16.sv | 110 +++++++++++
 2 files changed

// File: rtl/fracnet_sdiv_q16_pkg.sv
// Shared types, widths and the restoring-division step for fracnet_sdiv_q16.
package fracnet_sdiv_q16_pkg;

    localparam int DIVIDEND_W = 31;
    localparam int DIVISOR_W  = 15;
    localparam int QUOT_W     = 16;
    localparam int REM_W      = DIVISOR_W + 1;
    localparam int CNT_W      = 5;

    typedef logic [1:0] state_t;
    localparam state_t S_IDLE = 2'd0;
    localparam state_t S_CALC = 2'd1;
    localparam state_t S_FIX  = 2'd2;

    localparam logic [QUOT_W-1:0] QMAX = 16'h7fff;
    localparam logic [QUOT_W-1:0] QMIN = 16'h8000;

    // Largest magnitudes representable as positive / negative quotients.
    localparam logic [DIVIDEND_W-1:0] MAG_POS_MAX = 31'd32767;
    localparam logic [DIVIDEND_W-1:0] MAG_NEG_MAX = 31'd32768;

    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(DIVIDEND_W - 1);

    typedef struct packed {
        logic [REM_W-1:0] rem;
        logic             qbit;
    } step_t;

    function automatic step_t div_step(
        input logic [REM_W-1:0]     r_in,
        input logic                 b,
        input logic [DIVISOR_W-1:0] d
    );
        logic [REM_W:0] t;
        logic [REM_W:0] dx;
        step_t          s;
        t  = {r_in, b};
        dx = {2'b00, d};
        if (t >= dx) begin
            s.rem  = REM_W'(t - dx);
            s.qbit = 1'b1;
        end else begin
            s.rem  = REM_W'(t);
            s.qbit = 1'b0;
        end
        return s;
    endfunction

endpackage

// File: rtl/fracnet_sdiv_q16.sv
// Sequential signed/unsigned restoring divider with saturated Q16 quotient,
// remainder, overflow and divide-by-zero flags behind an ap_ctrl_hs handshake.
module fracnet_sdiv_q16
    import fracnet_sdiv_q16_pkg::*;
(
    input  logic                  ap_clk,
    input  logic                  ap_rst,
    input  logic                  ap_start,
    output logic                  ap_done,
    output logic                  ap_idle,
    output logic                  ap_ready,
    input  logic [DIVIDEND_W-1:0] din0,
    input  logic [DIVISOR_W-1:0]  din1,
    output logic [QUOT_W-1:0]     quot,
    output logic [QUOT_W-1:0]     rem,
    output logic                  ovf,
    output logic                  dbz
);

    state_t                state;
    logic [CNT_W-1:0]      cnt;
    // Holds remaining dividend bits (MSB side) and the growing quotient (LSB side).
    logic [DIVIDEND_W-1:0] acc;
    logic [REM_W-1:0]      r;
    logic [DIVISOR_W-1:0]  dvs;
    logic                  neg;
    logic                  zero;

    logic [DIVIDEND_W-1:0] din_mag;
    step_t                 st;
    logic [QUOT_W-1:0]     fix_quot;
    logic [QUOT_W-1:0]     fix_rem;
    logic                  fix_ovf;

    assign ap_idle  = (state == S_IDLE);
    assign ap_ready = ap_done;

    // -2^30 negates onto itself, which is exactly its unsigned magnitude.
    assign din_mag = din0[DIVIDEND_W-1] ? (~din0 + 1'b1) : din0;
    assign st      = div_step(r, acc[DIVIDEND_W-1], dvs);

    always_comb begin
        fix_quot = '0;
        fix_rem  = '0;
        fix_ovf  = 1'b0;
        if (zero) begin
            fix_quot = neg ? QMIN : QMAX;
        end else begin
            fix_rem = neg ? (QUOT_W'(0) - r) : r;
            if (!neg && acc > MAG_POS_MAX) begin
                fix_quot = QMAX;
                fix_ovf  = 1'b1;
            end else if (neg && acc > MAG_NEG_MAX) begin
                fix_quot = QMIN;
                fix_ovf  = 1'b1;
            end else begin
                fix_quot = neg ? (QUOT_W'(0) - acc[QUOT_W-1:0])
                               : acc[QUOT_W-1:0];
            end
        end
    end

    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            state   <= S_IDLE;
            cnt     <= '0;
            acc     <= '0;
            r       <= '0;
            dvs     <= '0;
            neg     <= 1'b0;
            zero    <= 1'b0;
            ap_done <= 1'b0;
            quot    <= '0;
            rem     <= '0;
            ovf     <= 1'b0;
            dbz     <= 1'b0;
        end else begin
            ap_done <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (ap_start) begin
                        neg   <= din0[DIVIDEND_W-1];
                        acc   <= din_mag;
                        dvs   <= din1;
                        r     <= '0;
                        cnt   <= CNT_INIT;
                        zero  <= (din1 == '0);
                        state <= (din1 == '0) ? S_FIX : S_CALC;
                    end
                end
                S_CALC: begin
                    acc <= {acc[DIVIDEND_W-2:0], st.qbit};
                    r   <= st.rem;
                    if (cnt == '0) state <= S_FIX;
                    else cnt <= cnt - 1'b1;
                end
                S_FIX: begin
                    quot    <= fix_quot;
                    rem     <= fix_rem;
                    ovf     <= fix_ovf;
                    dbz     <= zero;
                    ap_done <= 1'b1;
                    state   <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
